// File: rtl/stickit_decoder.sv
// ---------------------------------------------------------------------------
// stickit_decoder
//
// Receive-side decoder for the StickIt! LED Digits charlieplexed 8-line
// interface. Watches the eight tristate lines (driven level plus output
// enable), waits for a pattern to hold steady, identifies the scanned digit
// and its segment pattern, maps the pattern back to a hex nibble and
// assembles a full 8-digit frame into a 32-bit value.
//
// Parameters
//   STABLE_CYCLES : consecutive identical samples needed to accept a
//                   pattern (legal range 1..15)
//
// Ports
//   CLK       in   1  system clock
//   RESET     in   1  synchronous, active-high reset
//   S_OUT     in   8  driven level of each line
//   S_OE      in   8  1 = line driven, 0 = line high-Z
//   VALUE     out 32  last complete frame, digit k in [4k+3:4k]
//   VALID     out  1  one-cycle pulse when VALUE is updated
//   ERROR     out  1  one-cycle pulse when an accepted pattern is rejected
//   SYNCED    out  1  high while collecting a frame
//   ERR_COUNT out  8  saturating count of rejected patterns
//
// Build option
//   STICKIT_DEC_ERRCNT_EN : when defined, ERR_COUNT counts ERROR pulses and
//                           saturates at 255; otherwise it is tied to 0.
// ---------------------------------------------------------------------------
module stickit_decoder #(
    parameter int STABLE_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  S_OUT,
    input  logic [7:0]  S_OE,
    output logic [31:0] VALUE,
    output logic        VALID,
    output logic        ERROR,
    output logic        SYNCED,
    output logic [7:0]  ERR_COUNT
);

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES - 1);
    localparam logic [3:0] STABLE_MAX  = 4'(STABLE_CYCLES);

    // -----------------------------------------------------------------------
    // Sampling and stability
    // -----------------------------------------------------------------------
    logic [15:0] raw;
    logic [15:0] smp;
    logic [15:0] last_acc;
    logic [3:0]  stable_cnt;
    logic        same;
    logic        accept;

    assign raw = {S_OE, S_OUT};

    // The incoming sample is compared against the one already held in smp,
    // so a pattern presented from cycle t reaches the acceptance count on
    // the edge ending cycle t+STABLE_CYCLES.
    assign same   = (raw == smp);
    assign accept = same && (stable_cnt == STABLE_LAST) && (smp != last_acc);

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            smp        <= '0;
            last_acc   <= '0;
            stable_cnt <= '0;
        end else begin
            smp <= raw;
            if (!same) begin
                stable_cnt <= '0;
            end else if (stable_cnt != STABLE_MAX) begin
                stable_cnt <= stable_cnt + 4'd1;
            end
            if (accept) begin
                last_acc <= smp;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pattern decode (operates on the held sample)
    // -----------------------------------------------------------------------
    logic [7:0] oe_s;
    logic [7:0] out_s;
    logic [7:0] scan_mask;
    logic [7:0] lit;
    logic       scan_ok;
    logic [2:0] scan_idx;
    logic [6:0] seg;
    logic       glyph_ok;
    logic [3:0] nibble;
    logic       bad;

    assign oe_s      = smp[15:8];
    assign out_s     = smp[7:0];
    assign scan_mask = oe_s & out_s;
    assign lit       = oe_s & ~out_s;

    // Exactly one driven-high line: non-zero and clearing the lowest set bit
    // leaves nothing behind.
    assign scan_ok = (scan_mask != 8'd0) &&
                     ((scan_mask & (scan_mask - 8'd1)) == 8'd0);

    always_comb begin
        scan_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (scan_mask[i]) begin
                scan_idx = 3'(i);
            end
        end
    end

    // Remove the scan line and close the gap: lines below it keep their
    // position, lines above it shift down by one.
    always_comb begin
        seg = '0;
        for (int i = 0; i < 7; i++) begin
            seg[i] = (3'(i) < scan_idx) ? lit[i] : lit[i + 1];
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        nibble   = 4'h0;
        glyph_ok = 1'b1;
        case (seg)
            7'b0111111: nibble = 4'h0;
            7'b0000110: nibble = 4'h1;
            7'b1011011: nibble = 4'h2;
            7'b1001111: nibble = 4'h3;
            7'b1100110: nibble = 4'h4;
            7'b1101101: nibble = 4'h5;
            7'b1111101: nibble = 4'h6;
            7'b0000111: nibble = 4'h7;
            7'b1111111: nibble = 4'h8;
            7'b1101111: nibble = 4'h9;
            7'b1110111: nibble = 4'hA;
            7'b1111100: nibble = 4'hB;
            7'b0111001: nibble = 4'hC;
            7'b1011110: nibble = 4'hD;
            7'b1111001: nibble = 4'hE;
            7'b1110001: nibble = 4'hF;
            default:    glyph_ok = 1'b0;
        endcase
    end

    assign bad = !scan_ok || !glyph_ok;

    // -----------------------------------------------------------------------
    // Frame FSM
    // -----------------------------------------------------------------------
    state_t      state;
    state_t      state_next;
    logic [2:0]  expected;
    logic [2:0]  expected_next;
    // Digit 7 goes straight into VALUE, so only digits 0..6 need shadowing.
    logic [27:0] shadow;
    logic [27:0] shadow_next;
    logic [31:0] value_next;
    logic        valid_next;
    logic        error_next;

    always_comb begin
        state_next    = state;
        expected_next = expected;
        shadow_next   = shadow;
        value_next    = VALUE;
        valid_next    = 1'b0;
        error_next    = 1'b0;

        if (accept) begin
            if (bad) begin
                // Malformed or unknown glyph: drop sync, keep shadow as is.
                error_next = 1'b1;
                state_next = HUNT;
            end else if (state == HUNT) begin
                // Only digit 0 can start a frame; anything else is ignored.
                if (scan_idx == 3'd0) begin
                    shadow_next[3:0] = nibble;
                    expected_next    = 3'd1;
                    state_next       = COLLECT;
                end
            end else if (scan_idx == expected) begin
                if (expected == 3'd7) begin
                    value_next    = {nibble, shadow};
                    valid_next    = 1'b1;
                    expected_next = 3'd0;
                    state_next    = HUNT;
                end else begin
                    for (int d = 0; d < 7; d++) begin
                        if (scan_idx == 3'(d)) begin
                            shadow_next[4*d +: 4] = nibble;
                        end
                    end
                    expected_next = expected + 3'd1;
                end
            end else begin
                // Out of order. A fresh digit 0 restarts the frame in place.
                error_next = 1'b1;
                if (scan_idx == 3'd0) begin
                    shadow_next[3:0] = nibble;
                    expected_next    = 3'd1;
                end else begin
                    state_next = HUNT;
                end
            end
        end
    end

    // NOTE: the shadow is an ordinary register (not a RAM), so it is cleared
    // on reset to guarantee a mid-frame reset discards partial data.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= HUNT;
            expected <= '0;
            shadow   <= '0;
            VALUE    <= '0;
            VALID    <= 1'b0;
            ERROR    <= 1'b0;
        end else begin
            state    <= state_next;
            expected <= expected_next;
            shadow   <= shadow_next;
            VALUE    <= value_next;
            VALID    <= valid_next;
            ERROR    <= error_next;
        end
    end

    assign SYNCED = (state == COLLECT);

    // -----------------------------------------------------------------------
    // Optional error counter
    // -----------------------------------------------------------------------
`ifdef STICKIT_DEC_ERRCNT_EN
    logic [7:0] err_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            err_cnt <= '0;
        end else if (error_next && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign ERR_COUNT = err_cnt;
`else
    assign ERR_COUNT = '0;
`endif

endmodule

// File: tb/tb_stickit_decoder.sv
// ---------------------------------------------------------------------------
// tb_stickit_decoder
//
// Self-checking bench for stickit_decoder. A behavioural model (run length
// of the driven pattern, queue-based pattern classification, glyph lookup
// by table search, frame assembled from a nibble array) predicts every
// output each cycle. Directed rows cover the frame scenarios; hand-written
// sequences cover error counting, saturation and mid-frame reset; a random
// phase exercises arbitrary digit orders, hold times and garbage patterns.
// ---------------------------------------------------------------------------
module tb_stickit_decoder;

    localparam int S = 2;
`ifdef STICKIT_DEC_ERRCNT_EN
    localparam bit ERRCNT_EN = 1'b1;
`else
    localparam bit ERRCNT_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  S_OUT;
    logic [7:0]  S_OE;
    logic [31:0] VALUE;
    logic        VALID;
    logic        ERROR;
    logic        SYNCED;
    logic [7:0]  ERR_COUNT;

    stickit_decoder #(.STABLE_CYCLES(S)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .S_OUT     (S_OUT),
        .S_OE      (S_OE),
        .VALUE     (VALUE),
        .VALID     (VALID),
        .ERROR     (ERROR),
        .SYNCED    (SYNCED),
        .ERR_COUNT (ERR_COUNT)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int win_valid;
    int win_error;

    logic [6:0] glyph [16];

    // Reference model state
    logic [15:0] m_prev;
    logic [15:0] m_last;
    int          m_run;
    bit          m_sync;
    int          m_next;
    logic [3:0]  m_frame [8];
    logic [31:0] m_value;
    bit          m_valid;
    bit          m_error;
    int          m_errcnt;

    typedef struct {
        string       name;
        logic [15:0] pat;
        int          hold;
        int          exp_valid;
        int          exp_error;
        bit          exp_sync;
        logic [31:0] exp_value;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_prev   = '0;
        m_last   = '0;
        m_run    = 1;
        m_sync   = 1'b0;
        m_next   = 0;
        m_value  = '0;
        m_valid  = 1'b0;
        m_error  = 1'b0;
        m_errcnt = 0;
        for (int d = 0; d < 8; d++) m_frame[d] = '0;
    endtask

    task automatic model_count_error();
        m_error = 1'b1;
        if (ERRCNT_EN && m_errcnt < 255) m_errcnt++;
    endtask

    task automatic model_accept(input logic [15:0] p);
        logic [7:0] oe;
        logic [7:0] out;
        int         scans[$];
        bit         lits[$];
        logic [6:0] seg;
        int         k;
        int         nib;
        oe  = p[15:8];
        out = p[7:0];
        k   = -1;
        nib = -1;
        for (int i = 0; i < 8; i++) if (oe[i] && out[i]) scans.push_back(i);
        if (scans.size() == 1) begin
            k = scans[0];
            for (int i = 0; i < 8; i++) if (i != k) lits.push_back(oe[i] && !out[i]);
            seg = '0;
            for (int j = 0; j < 7; j++) seg[j] = lits[j];
            for (int n = 0; n < 16; n++) if (glyph[n] == seg) nib = n;
        end
        if (nib < 0) begin
            model_count_error();
            m_sync = 1'b0;
        end else if (!m_sync) begin
            if (k == 0) begin
                m_frame[0] = 4'(nib);
                m_next     = 1;
                m_sync     = 1'b1;
            end
        end else if (k == m_next) begin
            m_frame[k] = 4'(nib);
            if (k == 7) begin
                m_value = '0;
                for (int d = 0; d < 8; d++) m_value = m_value + (32'(m_frame[d]) << (4 * d));
                m_valid = 1'b1;
                m_sync  = 1'b0;
            end else begin
                m_next++;
            end
        end else begin
            model_count_error();
            if (k == 0) begin
                m_frame[0] = 4'(nib);
                m_next     = 1;
            end else begin
                m_sync = 1'b0;
            end
        end
    endtask

    // One cycle of input: a pattern is accepted when it has been driven for
    // exactly S+1 consecutive cycles and differs from the last accepted one.
    task automatic model_cycle(input logic [15:0] p);
        m_valid = 1'b0;
        m_error = 1'b0;
        if (p == m_prev) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run  = 1;
            m_prev = p;
        end
        if (m_run == S + 1 && p != m_last) begin
            m_last = p;
            model_accept(p);
        end
    endtask

    task automatic step(input logic [15:0] p);
        S_OE  = p[15:8];
        S_OUT = p[7:0];
        model_cycle(p);
        @(posedge CLK);
        #1;
        check("cycle", {21'd0, VALUE, VALID, ERROR, SYNCED, ERR_COUNT},
              {21'd0, m_value, m_valid, m_error, m_sync, 8'(m_errcnt)});
        win_valid += int'(VALID);
        win_error += int'(ERROR);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        S_OE  = '0;
        S_OUT = '0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        model_reset();
        check("reset VALUE", VALUE, 0);
        check("reset VALID", VALID, 0);
        check("reset ERROR", ERROR, 0);
        check("reset SYNCED", SYNCED, 0);
        check("reset ERR_COUNT", ERR_COUNT, 0);
    endtask

    // Builds {OE,OUT} for digit k showing nibble nib; undriven lines carry
    // the noise bits on OUT, which must not matter.
    function automatic logic [15:0] make_pat(input int k, input logic [3:0] nib, input logic [7:0] noise);
        logic [7:0] oe;
        logic [7:0] out;
        logic [6:0] seg;
        int         j;
        seg = glyph[nib];
        j   = 0;
        oe  = '0;
        out = '0;
        for (int i = 0; i < 8; i++) begin
            if (i == k) begin
                oe[i]  = 1'b1;
                out[i] = 1'b1;
            end else begin
                oe[i]  = seg[j];
                out[i] = seg[j] ? 1'b0 : noise[i];
                j++;
            end
        end
        return {oe, out};
    endfunction

    task automatic add_row(input string name, input logic [15:0] pat, input int hold,
                           input int ev, input int ee, input bit es, input logic [31:0] eval);
        vec_t v;
        v.name      = name;
        v.pat       = pat;
        v.hold      = hold;
        v.exp_valid = ev;
        v.exp_error = ee;
        v.exp_sync  = es;
        v.exp_value = eval;
        vecs.push_back(v);
    endtask

    // Full in-order frame: SYNCED from digit 0 to 6, VALID on digit 7.
    task automatic add_frame(input string name, input logic [31:0] val, input logic [31:0] prev);
        for (int d = 0; d < 8; d++) begin
            add_row($sformatf("%s d%0d", name, d), make_pat(d, val[4*d +: 4], 8'h00), 4,
                    (d == 7) ? 1 : 0, 0, (d != 7), (d == 7) ? val : prev);
        end
    endtask

    localparam logic [15:0] TWO_SCAN = 16'h0303;
    localparam logic [15:0] UNKNOWN  = 16'h0301;
    localparam logic [15:0] TWO_SCAN_B = 16'h0C0C;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pat;
        int          nd;

        glyph[0]  = 7'b0111111; glyph[1]  = 7'b0000110; glyph[2]  = 7'b1011011; glyph[3]  = 7'b1001111;
        glyph[4]  = 7'b1100110; glyph[5]  = 7'b1101101; glyph[6]  = 7'b1111101; glyph[7]  = 7'b0000111;
        glyph[8]  = 7'b1111111; glyph[9]  = 7'b1101111; glyph[10] = 7'b1110111; glyph[11] = 7'b1111100;
        glyph[12] = 7'b0111001; glyph[13] = 7'b1011110; glyph[14] = 7'b1111001; glyph[15] = 7'b1110001;

        win_valid = 0;
        win_error = 0;
        model_reset();
        do_reset();

        // Directed table
        add_frame("f1234ABCD", 32'h1234ABCD, 32'h0);
        for (int d = 3; d < 8; d++)
            add_row($sformatf("ignore d%0d", d), make_pat(d, 4'hF, 8'h00), 4, 0, 0, 1'b0, 32'h1234ABCD);
        add_frame("fFFFFFFFF", 32'hFFFFFFFF, 32'h1234ABCD);
        for (int d = 0; d < 3; d++)
            add_row($sformatf("partial d%0d", d), make_pat(d, 4'h3, 8'h00), 4, 0, 0, 1'b1, 32'hFFFFFFFF);
        add_row("ooo d5", make_pat(5, 4'h0, 8'h00), 4, 0, 1, 1'b0, 32'hFFFFFFFF);
        add_frame("f00000000", 32'h0, 32'hFFFFFFFF);
        for (int d = 0; d < 4; d++)
            add_row($sformatf("short d%0d", d), make_pat(d, 4'h1, 8'h00), 1, 0, 0, 1'b0, 32'h0);
        add_frame("f89ABCDEF", 32'h89ABCDEF, 32'h0);
        add_row("mid d0", make_pat(0, 4'h2, 8'hF0), 4, 0, 0, 1'b1, 32'h89ABCDEF);
        add_row("mid d1", make_pat(1, 4'h2, 8'h0F), 4, 0, 0, 1'b1, 32'h89ABCDEF);

        for (int r = 0; r < vecs.size(); r++) begin
            win_valid = 0;
            win_error = 0;
            for (int h = 0; h < vecs[r].hold; h++) step(vecs[r].pat);
            check({vecs[r].name, " valid"}, win_valid, vecs[r].exp_valid);
            check({vecs[r].name, " error"}, win_error, vecs[r].exp_error);
            check({vecs[r].name, " synced"}, SYNCED, vecs[r].exp_sync);
            check({vecs[r].name, " value"}, VALUE, vecs[r].exp_value);
        end

        // Mid-frame reset: everything back to reset values next cycle.
        do_reset();

        // Two scan-high lines then an unknown glyph.
        win_valid = 0;
        win_error = 0;
        for (int h = 0; h < 4; h++) step(TWO_SCAN);
        for (int h = 0; h < 4; h++) step(UNKNOWN);
        check("bad errors", win_error, 2);
        check("bad valids", win_valid, 0);
        check("bad errcnt", ERR_COUNT, ERRCNT_EN ? 2 : 0);

        // Error counter saturation.
        for (int n = 0; n < 130; n++) begin
            for (int h = 0; h < S + 1; h++) step(TWO_SCAN_B);
            for (int h = 0; h < S + 1; h++) step(TWO_SCAN);
        end
        check("errcnt sat", ERR_COUNT, ERRCNT_EN ? 255 : 0);

        // Randomised stream against the model.
        do_reset();
        nd = 0;
        for (int n = 0; n < 600; n++) begin
            int r;
            int hold;
            r    = $urandom_range(0, 19);
            hold = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : $urandom_range(3, 6);
            if (r < 15) begin
                pat = make_pat(nd, 4'($urandom_range(0, 15)), 8'($urandom));
                nd  = (nd + 1) % 8;
            end else if (r < 17) begin
                pat = make_pat($urandom_range(0, 7), 4'($urandom_range(0, 15)), 8'($urandom));
            end else if (r < 19) begin
                pat = 16'($urandom);
            end else begin
                pat = make_pat(0, 4'($urandom_range(0, 15)), 8'($urandom));
                nd  = 1;
            end
            for (int h = 0; h < hold; h++) step(pat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stickit_decoder.md
# stickit_decoder

Receive-side decoder for the StickIt! LED Digits charlieplexed 8-line interface. Observes the 8 tristate lines in split form (driven level plus output enable), identifies the scanned digit and its segment pattern, maps the pattern back to a hex nibble, and assembles a full 8-digit frame into a 32-bit value. Used as an in-fabric loopback monitor beside the display driver and as a self-checking verification component.

## Interface
- `STABLE_CYCLES`, default 2: consecutive identical samples needed to accept a pattern; legal range 1..15.
- `CLK`, input, 1: system clock.
- `RESET`, input, 1: synchronous, active-high reset.
- `S_OUT`, input, 8: driven level of each line; synchronous to `CLK`.
- `S_OE`, input, 8: 1 = line driven, 0 = line high-Z.
- `VALUE`, output, 32: last complete frame; digit k is held in `[4k+3:4k]`.
- `VALID`, output, 1: one-cycle pulse when `VALUE` is updated.
- `ERROR`, output, 1: one-cycle pulse when an accepted pattern is rejected.
- `SYNCED`, output, 1: high while in the COLLECT state.
- `ERR_COUNT`, output, 8: saturating count of rejected patterns (see Configuration).

## Operation
- Sample register: `{S_OE,S_OUT}` registered every cycle into `smp`.
- Stability: counter increments while `smp` equals the previous `smp`, saturating at `STABLE_CYCLES`. A pattern is *accepted* exactly once: on the cycle the count reaches `STABLE_CYCLES` and the pattern differs from the last accepted pattern. Any change resets the count.
- Scan line: the unique line k with OE=1 and OUT=1. The pattern is malformed if no such line exists or if more than one exists.
- Segment word: seg[6:0] is the 8 lines with line k removed, in order, upper lines to upper bits. Segment bit = lit when OE=1 and OUT=0; off when OE=0. A non-scan line with OE=1 and OUT=1 is malformed.
- Lit masks seg[6:0] by nibble:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, B=1111100
  - C=0111001, D=1011110, E=1111001, F=1110001
  - Any other mask is an unknown glyph.
- FSM states HUNT and COLLECT. `expected` is 3 bits.
  - HUNT, accepting a valid digit 0: store the nibble in shadow[3:0], set `expected`=1, go to COLLECT.
  - HUNT, accepting a valid digit other than 0: ignore silently.
  - COLLECT, accepting a valid digit k equal to `expected`: store the nibble in shadow[4k+3:4k] and increment `expected`.
  - COLLECT, accepting a valid digit 7 when `expected`=7: update `VALUE` to {nibble, shadow[27:0]}, pulse `VALID`, go to HUNT.
  - COLLECT, accepting a valid digit not equal to `expected`: out-of-order. Pulse `ERROR`. If k=0, restart the frame (store the nibble, `expected`=1, stay in COLLECT); otherwise go to HUNT.
- Malformed or unknown-glyph pattern in any state: pulse `ERROR`, go to HUNT, leave shadow untouched.
- `VALUE` changes only on frame completion. Partial frames are never exposed.

## Timing
- Reset values: `VALUE`=0, `VALID`=0, `ERROR`=0, `SYNCED`=0, `ERR_COUNT`=0, FSM in HUNT, `expected`=0, stability count=0, last-accepted pattern = all-zero (OE=0, which is malformed and never matches a legal pattern).
- Latency: a pattern presented from cycle t and held is accepted at the edge ending cycle t+`STABLE_CYCLES`. `VALID`/`ERROR`/`SYNCED`/`VALUE` reflect that acceptance in cycle t+`STABLE_CYCLES`+1.
- Patterns held shorter than `STABLE_CYCLES`+1 cycles are never accepted and produce no error.
- `VALID` and `ERROR` are mutually exclusive in a cycle.
- `RESET` mid-frame discards the shadow and returns to HUNT on the next edge.
- `expected` wraps 7→0 only through frame completion.

## Configuration
- `STICKIT_DEC_ERRCNT_EN` defined: `ERR_COUNT` increments on every `ERROR` pulse and saturates at 255. It clears only on `RESET`.
- Not defined: `ERR_COUNT` is tied to 0 and no counter logic is built.

## Test plan
- Drive the digits for value 0x1234ABCD in order 0..7, 4 cycles each (`STABLE_CYCLES`=2): `VALUE`=0x1234ABCD with one `VALID` pulse in the cycle after digit 7 is accepted; `ERROR` never asserts.
- Start the stream at digit 3, then run a full 0..7 frame of 0xFFFFFFFF: digits 3..7 ignored, `SYNCED` rises after digit 0, `VALUE`=0xFFFFFFFF, no `ERROR`.
- Inject digit 5 after digit 2 within a frame: one `ERROR`, `SYNCED`=0, `VALUE` unchanged; the next clean frame of 0x00000000 is captured.
- Present two scan-high lines, then an unknown glyph 0000001: two `ERROR` pulses; `ERR_COUNT`=2 with the macro defined, 0 without.
- Hold each pattern 1 cycle only (`STABLE_CYCLES`=2): no acceptance, no `VALID`/`ERROR`. Then assert `RESET` mid-frame: all outputs return to their reset values next cycle.
